uart_hex_loader: RTL and testbench

Serial loader upstream of the block RAM. It receives UART text records in the same `$AAAA#HH HH ...<CR>` format the BRAM dumper emits, parses the hex, and drives a byte-wide write port (address, data, strobe) into the RAM. A dump captured from the board can therefore be edited and sent back to reload memory. The block sits beside the dumper at top level: it takes its input from a new RX pin and feeds the RAM write side.

---
 rtl/uart_hex_loader_if.sv | 19 +
 rtl/uart_hex_loader.sv | 181 ++++++++++++++++++
 tb/tb_uart_hex_loader.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_hex_loader_if.sv
// RAM write port plus status pulses produced by the UART hex loader.
interface uart_hex_loader_if #(
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] WrAddress;
  logic [7:0]        WrData;
  logic              WrEnable;
  logic              RecordDone;
  logic              FrameError;
  logic              SyntaxError;

  modport master (
    output WrAddress, WrData, WrEnable, RecordDone, FrameError, SyntaxError
  );

  modport slave (
    input  WrAddress, WrData, WrEnable, RecordDone, FrameError, SyntaxError
  );
endinterface

// File: rtl/uart_hex_loader.sv
// UART receiver + "$AAAA#HH HH ..<CR>" record parser driving a byte-wide RAM write port.
module uart_hex_loader #(
  parameter int CLK_HZ = 24000000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 11
) (
  input  logic                  clk,
  input  logic                  RESET_n,
  input  logic                  RxPin,
  uart_hex_loader_if.master     wr
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] HALF_C  = CW'(DIV / 2);
  localparam logic [CW-1:0] DIVM1_C = CW'(DIV - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
  typedef enum logic [2:0] {P_HUNT, P_ADDR, P_HASH, P_HI, P_LO} p_st_t;

  // Returns {valid, nibble}; 'A'-'F' and 'a'-'f' share low bits 1..6.
  function automatic logic [4:0] hex_dec(input logic [7:0] c);
    logic [4:0] r;
    r = '0;
    if (c >= 8'h30 && c <= 8'h39)
      r = {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      r = {1'b1, c[3:0] + 4'd9};
    return r;
  endfunction

  logic          rx_s1, rx_s2, armed;
  rx_st_t        rx_st;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg, rx_byte;
  logic          rx_valid;

  p_st_t             p_st;
  logic [1:0]        dcnt;
  logic [3:0]        hi_nib;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        hx;

  assign hx = hex_dec(rx_byte);

  // Two-flop synchronizer; resets low so a line held low at release is never taken as a start.
  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      rx_s1 <= 1'b0;
      rx_s2 <= 1'b0;
    end else begin
      rx_s1 <= RxPin;
      rx_s2 <= rx_s1;
    end
  end

  // 8N1 receiver: mid-bit sampling, glitch rejection on the start bit, frame error on low stop.
  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      rx_st         <= RX_IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      rx_byte       <= '0;
      rx_valid      <= 1'b0;
      armed         <= 1'b0;
      wr.FrameError <= 1'b0;
    end else begin
      rx_valid      <= 1'b0;
      wr.FrameError <= 1'b0;
      case (rx_st)
        RX_IDLE: begin
          if (rx_s2) armed <= 1'b1;
          if (armed && !rx_s2) begin
            rx_st <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF_C) begin
            cnt     <= '0;
            bit_cnt <= '0;
            rx_st   <= rx_s2 ? RX_IDLE : RX_DATA;
          end else cnt <= cnt + CW'(1);
        end
        RX_DATA: begin
          if (cnt == DIVM1_C) begin
            cnt     <= '0;
            shreg   <= {rx_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) rx_st <= RX_STOP;
          end else cnt <= cnt + CW'(1);
        end
        RX_STOP: begin
          if (cnt == DIVM1_C) begin
            cnt <= '0;
            if (rx_s2) begin
              rx_valid <= 1'b1;
              rx_byte  <= shreg;
            end else wr.FrameError <= 1'b1;
            rx_st <= RX_IDLE;
          end else cnt <= cnt + CW'(1);
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // Record parser; the header digits shift straight into the address register since
  // no write can happen before the fourth digit reloads it completely.
  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      p_st           <= P_HUNT;
      dcnt           <= '0;
      hi_nib         <= '0;
      addr_q         <= '0;
      wr.WrAddress   <= '0;
      wr.WrData      <= '0;
      wr.WrEnable    <= 1'b0;
      wr.RecordDone  <= 1'b0;
      wr.SyntaxError <= 1'b0;
    end else begin
      wr.WrEnable    <= 1'b0;
      wr.RecordDone  <= 1'b0;
      wr.SyntaxError <= 1'b0;
      if (rx_valid && rx_byte != 8'h0A) begin
        if (rx_byte == 8'h24) begin
          p_st <= P_ADDR;
          dcnt <= '0;
        end else begin
          case (p_st)
            P_HUNT: ;
            P_ADDR: begin
              if (hx[4]) begin
                addr_q <= {addr_q[ADDR_W-5:0], hx[3:0]};
                dcnt   <= dcnt + 2'd1;
                if (dcnt == 2'd3) p_st <= P_HASH;
              end else begin
                wr.SyntaxError <= 1'b1;
                p_st           <= P_HUNT;
              end
            end
            P_HASH: begin
              if (rx_byte == 8'h23) p_st <= P_HI;
              else begin
                wr.SyntaxError <= 1'b1;
                p_st           <= P_HUNT;
              end
            end
            P_HI: begin
              if (rx_byte == 8'h20) ;
              else if (rx_byte == 8'h0D) begin
                wr.RecordDone <= 1'b1;
                p_st          <= P_HUNT;
              end else if (hx[4]) begin
                hi_nib <= hx[3:0];
                p_st   <= P_LO;
              end else begin
                wr.SyntaxError <= 1'b1;
                p_st           <= P_HUNT;
              end
            end
            P_LO: begin
              if (hx[4]) begin
                wr.WrData    <= {hi_nib, hx[3:0]};
                wr.WrAddress <= addr_q;
                wr.WrEnable  <= 1'b1;
                addr_q       <= addr_q + ADDR_W'(1);
                p_st         <= P_HI;
              end else begin
                wr.SyntaxError <= 1'b1;
                p_st           <= P_HUNT;
              end
            end
            default: p_st <= P_HUNT;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_hex_loader.sv
// Bench for uart_hex_loader: UART byte driver, event monitor and a string-level record model.
module tb_uart_hex_loader;
  localparam int BAUD = 115200;
  localparam int CLK_HZ = BAUD * 32;
  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW = 11;

  logic clk = 1'b0;
  logic RESET_n = 1'b0;
  logic RxPin = 1'b1;

  uart_hex_loader_if #(.ADDR_W(AW)) bus ();

  uart_hex_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(AW)) dut (
    .clk(clk), .RESET_n(RESET_n), .RxPin(RxPin), .wr(bus.master)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [AW+7:0] obs_wr[$], exp_wr[$];
  int obs_done, obs_syn, obs_frm;
  int exp_done, exp_syn, exp_frm;
  string CRs, LFs;

  // Record every strobe seen outside reset.
  always @(negedge clk) begin
    if (RESET_n) begin
      if (bus.WrEnable) obs_wr.push_back({bus.WrAddress, bus.WrData});
      if (bus.RecordDone) obs_done++;
      if (bus.SyntaxError) obs_syn++;
      if (bus.FrameError) obs_frm++;
    end
  end

  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  // Expected writes/pulses for a text stream entered while the parser is hunting.
  function automatic void model(input string s);
    int mode = 0; int nd = 0; int a16 = 0; int addr = 0; int hi = 0;
    exp_wr.delete(); exp_done = 0; exp_syn = 0; exp_frm = 0;
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] c;
      int v;
      c = s[i];
      v = hexval(c);
      if (c == 8'h0A) continue;
      if (c == "$") begin mode = 1; nd = 0; a16 = 0; continue; end
      case (mode)
        1: if (v >= 0) begin
             a16 = a16 * 16 + v; nd++;
             if (nd == 4) begin addr = a16 % (1 << AW); mode = 2; end
           end else begin exp_syn++; mode = 0; end
        2: if (c == "#") mode = 3; else begin exp_syn++; mode = 0; end
        3: if (c == " ") ;
           else if (c == 8'h0D) begin exp_done++; mode = 0; end
           else if (v >= 0) begin hi = v; mode = 4; end
           else begin exp_syn++; mode = 0; end
        4: if (v >= 0) begin
             exp_wr.push_back({AW'(addr), 8'(hi * 16 + v)});
             addr = (addr + 1) % (1 << AW); mode = 3;
           end else begin exp_syn++; mode = 0; end
        default: ;
      endcase
    end
  endfunction

  task automatic clear_obs();
    obs_wr.delete(); obs_done = 0; obs_syn = 0; obs_frm = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    RxPin = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      RxPin = b[k];
      repeat (DIV) @(negedge clk);
    end
    if (stop_ok) begin
      RxPin = 1'b1;
      repeat (DIV) @(negedge clk);
    end else begin
      RxPin = 1'b0;
      repeat (DIV / 2 + 6) @(negedge clk);
      RxPin = 1'b1;
      repeat (DIV) @(negedge clk);
    end
    RxPin = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic test_reset();
    RESET_n = 1'b0; RxPin = 1'b1;
    repeat (4) @(negedge clk);
    n_chk++;
    if ({bus.WrAddress, bus.WrData, bus.WrEnable, bus.RecordDone, bus.FrameError, bus.SyntaxError} !== '0)
      $display("FAIL reset_outputs got %h/%h/%b%b%b%b need all 0", bus.WrAddress, bus.WrData,
               bus.WrEnable, bus.RecordDone, bus.FrameError, bus.SyntaxError);
    else n_pass++;
    RESET_n = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic test_basic();
    string s;
    s = {"$0010#AB CD", CRs};
    model(s); clear_obs(); send_str(s);
    n_chk++; if (obs_wr.size() !== exp_wr.size()) $display("FAIL basic_nwr got %0d need %0d", obs_wr.size(), exp_wr.size()); else n_pass++;
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
      n_chk++; if (obs_wr[i] !== exp_wr[i]) $display("FAIL basic_wr%0d got %h need %h", i, obs_wr[i], exp_wr[i]); else n_pass++;
    end
    n_chk++; if (obs_done !== 1 || exp_done !== 1) $display("FAIL basic_done got %0d need 1", obs_done); else n_pass++;
    n_chk++; if (obs_syn + obs_frm !== 0) $display("FAIL basic_err got %0d need 0", obs_syn + obs_frm); else n_pass++;
    n_chk++; if ({bus.WrAddress, bus.WrData} !== {11'h011, 8'hCD}) $display("FAIL basic_hold got %h/%h need 011/cd", bus.WrAddress, bus.WrData); else n_pass++;
  endtask

  task automatic test_wrap_lf();
    string s;
    s = {"$07ff#11 22", CRs, LFs};
    model(s); clear_obs(); send_str(s);
    n_chk++; if (obs_wr.size() !== 2) $display("FAIL wrap_nwr got %0d need 2", obs_wr.size()); else n_pass++;
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
      n_chk++; if (obs_wr[i] !== exp_wr[i]) $display("FAIL wrap_wr%0d got %h need %h", i, obs_wr[i], exp_wr[i]); else n_pass++;
    end
    n_chk++; if (obs_done !== exp_done || obs_syn !== 0) $display("FAIL wrap_pulses got done=%0d syn=%0d need %0d/0", obs_done, obs_syn, exp_done); else n_pass++;
  endtask

  task automatic test_frame_error();
    string s;
    s = {"$0000#5A", CRs};
    model(s); exp_frm = 1; clear_obs();
    send_byte(8'h41, 1'b0);
    repeat (DIV) @(negedge clk);
    send_str(s);
    n_chk++; if (obs_frm !== exp_frm) $display("FAIL frame_cnt got %0d need %0d", obs_frm, exp_frm); else n_pass++;
    n_chk++; if (obs_wr.size() !== 1) $display("FAIL frame_nwr got %0d need 1", obs_wr.size()); else n_pass++;
    if (obs_wr.size() > 0) begin
      n_chk++; if (obs_wr[0] !== {11'h000, 8'h5A}) $display("FAIL frame_wr got %h need 0005a", obs_wr[0]); else n_pass++;
    end
    n_chk++; if (obs_syn !== 0 || obs_done !== 1) $display("FAIL frame_pulses got syn=%0d done=%0d need 0/1", obs_syn, obs_done); else n_pass++;
  endtask

  task automatic test_syntax();
    string s;
    s = {"$00G", "$0001#3", CRs, "$0002#7E", CRs};
    model(s); clear_obs(); send_str(s);
    n_chk++; if (obs_syn !== exp_syn) $display("FAIL syntax_cnt got %0d need %0d", obs_syn, exp_syn); else n_pass++;
    n_chk++; if (obs_wr.size() !== 1) $display("FAIL syntax_nwr got %0d need 1", obs_wr.size()); else n_pass++;
    if (obs_wr.size() > 0) begin
      n_chk++; if (obs_wr[0] !== {11'h002, 8'h7E}) $display("FAIL syntax_wr got %h need 0027e", obs_wr[0]); else n_pass++;
    end
    n_chk++; if (obs_done !== exp_done) $display("FAIL syntax_done got %0d need %0d", obs_done, exp_done); else n_pass++;
  endtask

  task automatic test_glitch();
    string s;
    clear_obs();
    RxPin = 1'b0;
    repeat (DIV / 2 - 6) @(negedge clk);
    RxPin = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    n_chk++;
    if (obs_wr.size() + obs_done + obs_syn + obs_frm !== 0)
      $display("FAIL glitch_quiet got %0d events need 0", obs_wr.size() + obs_done + obs_syn + obs_frm);
    else n_pass++;
    s = {"$0004#C3", CRs};
    model(s); clear_obs(); send_str(s);
    n_chk++; if (obs_wr.size() !== 1 || obs_frm !== 0) $display("FAIL glitch_after got nwr=%0d frm=%0d need 1/0", obs_wr.size(), obs_frm); else n_pass++;
    if (obs_wr.size() > 0) begin
      n_chk++; if (obs_wr[0] !== exp_wr[0]) $display("FAIL glitch_wr got %h need %h", obs_wr[0], exp_wr[0]); else n_pass++;
    end
  endtask

  task automatic test_reset_midframe();
    string s;
    logic [7:0] h;
    h = "#";
    clear_obs();
    for (int i = 0; i < 5; i++) begin
      s = "$0100";
      send_byte(s[i], 1'b1);
    end
    RxPin = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      RxPin = h[k];
      repeat (DIV) @(negedge clk);
    end
    #3 RESET_n = 1'b0; RxPin = 1'b0;
    #1;
    n_chk++;
    if ({bus.WrAddress, bus.WrData, bus.WrEnable, bus.RecordDone, bus.FrameError, bus.SyntaxError} !== '0)
      $display("FAIL midreset_outputs got %h/%h need all 0", bus.WrAddress, bus.WrData);
    else n_pass++;
    repeat (5) @(negedge clk);
    RESET_n = 1'b1;
    repeat (20) @(negedge clk);
    RxPin = 1'b1;
    repeat (DIV) @(negedge clk);
    s = {"$0003#FF", CRs};
    model(s); clear_obs(); send_str(s);
    n_chk++; if (obs_wr.size() !== 1) $display("FAIL midreset_nwr got %0d need 1", obs_wr.size()); else n_pass++;
    if (obs_wr.size() > 0) begin
      n_chk++; if (obs_wr[0] !== {11'h003, 8'hFF}) $display("FAIL midreset_wr got %h need 003ff", obs_wr[0]); else n_pass++;
    end
    n_chk++; if (obs_frm + obs_syn !== 0 || obs_done !== 1) $display("FAIL midreset_pulses got frm=%0d syn=%0d done=%0d need 0/0/1", obs_frm, obs_syn, obs_done); else n_pass++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      string s;
      int a, nb;
      s = ($urandom_range(1) != 0) ? "zq" : "";
      a = $urandom_range(16'hFFFF);
      s = {s, "$", ($urandom_range(1) != 0) ? $sformatf("%04X", a) : $sformatf("%04x", a), "#"};
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        int d;
        d = $urandom_range(255);
        s = {s, ($urandom_range(1) != 0) ? $sformatf("%02X", d) : $sformatf("%02x", d)};
        if ($urandom_range(1) != 0) s = {s, " "};
      end
      case ($urandom_range(3))
        0: s = {s, "Z"};
        1: s = {s, CRs, LFs};
        default: s = {s, CRs};
      endcase
      model(s); clear_obs(); send_str(s);
      n_chk++; if (obs_wr.size() !== exp_wr.size()) $display("FAIL rand%0d_nwr got %0d need %0d", r, obs_wr.size(), exp_wr.size()); else n_pass++;
      for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
        n_chk++; if (obs_wr[i] !== exp_wr[i]) $display("FAIL rand%0d_wr%0d got %h need %h", r, i, obs_wr[i], exp_wr[i]); else n_pass++;
      end
      n_chk++;
      if (obs_done !== exp_done || obs_syn !== exp_syn || obs_frm !== 0)
        $display("FAIL rand%0d_pulses got done=%0d syn=%0d frm=%0d need %0d/%0d/0", r, obs_done, obs_syn, obs_frm, exp_done, exp_syn);
      else n_pass++;
    end
  endtask

  initial begin
    CRs = $sformatf("%c", 8'h0D);
    LFs = $sformatf("%c", 8'h0A);
    test_reset();
    test_basic();
    test_wrap_lf();
    test_frame_error();
    test_syntax();
    test_glitch();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
